// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//
// General-purpose up/down counter used as a timer or index generator.
// Supports a programmable step, runtime inclusive bounds [lo,hi], and three
// end-of-range behaviours: wrap, saturate and one-shot. A one-cycle
// terminal-count pulse, a one-shot done level, a sticky overflow flag and a
// bound-configuration error flag are provided.
//
// Parameters:
//   DATA_WIDTH : width of count, load, step and bound values
//   RST_VAL    : dataout value while/after reset
//
// Ports:
//   clk      in   clock, all state updates on posedge
//   rst      in   asynchronous active-low reset
//   en       in   count enable, one step per clock while high
//   ld       in   synchronous load of datain (wins over en)
//   up       in   1 = increment, 0 = decrement
//   mode     in   00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
//   step     in   unsigned step magnitude
//   lo, hi   in   inclusive lower / upper bound
//   datain   in   load value
//   dataout  out  registered count
//   tc       out  registered one-cycle terminal-count pulse
//   done     out  one-shot finished (level)
//   ovf      out  sticky: any wrap or clamp since last load or reset
//   cfg_err  out  combinational: lo > hi
// -----------------------------------------------------------------------------
module param_updown_counter #(
  parameter int unsigned              DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]    RST_VAL    = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  ld,
  input  logic                  up,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic [DATA_WIDTH-1:0] lo,
  input  logic [DATA_WIDTH-1:0] hi,
  input  logic [DATA_WIDTH-1:0] datain,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  tc,
  output logic                  done,
  output logic                  ovf,
  output logic                  cfg_err
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  // Clamp a value into [lo_v, hi_v]; only meaningful when lo_v <= hi_v.
  function automatic logic [DATA_WIDTH-1:0] clamp_to_range(
    input logic [DATA_WIDTH-1:0] v,
    input logic [DATA_WIDTH-1:0] lo_v,
    input logic [DATA_WIDTH-1:0] hi_v
  );
    logic [DATA_WIDTH-1:0] r;
    if (v < lo_v) begin
      r = lo_v;
    end else if (v > hi_v) begin
      r = hi_v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Registered state
  logic [DATA_WIDTH-1:0] dataout_q;
  logic                  tc_q;
  logic                  done_q;
  logic                  ovf_q;
  state_e                state_q;

  // Combinational helpers
  logic                  cfg_err_s;
  logic                  sat_mode_s;
  logic                  oneshot_s;
  logic                  count_en_s;
  logic [DATA_WIDTH:0]   sum_s;
  logic [DATA_WIDTH:0]   diff_s;
  logic [DATA_WIDTH:0]   next_s;
  logic                  oor_s;
  logic [DATA_WIDTH-1:0] dir_bound_s;
  logic [DATA_WIDTH-1:0] load_val_s;

  // Candidate next-state values for an enabled counting step
  logic [DATA_WIDTH-1:0] cnt_step_d;
  logic                  tc_step_d;

  assign cfg_err_s = (lo > hi);

  // With inverted bounds the load value is kept exactly as given.
  assign load_val_s = cfg_err_s ? datain : clamp_to_range(datain, lo, hi);

  // Counting only happens in RUN, with valid bounds and a non-zero step.
  assign count_en_s = en && !cfg_err_s && (step != {DATA_WIDTH{1'b0}})
                      && (state_q == ST_RUN);

  // Decode the end-of-range behaviour selected by mode.
  always_comb begin
    sat_mode_s = 1'b0;
    oneshot_s  = 1'b0;
    case (mode)
      MODE_SAT: begin
        sat_mode_s = 1'b1;
        oneshot_s  = 1'b0;
      end
      MODE_ONESHOT: begin
        sat_mode_s = 1'b1;
        oneshot_s  = 1'b1;
      end
      MODE_WRAP: begin
        sat_mode_s = 1'b0;
        oneshot_s  = 1'b0;
      end
      default: begin
        sat_mode_s = 1'b0;
        oneshot_s  = 1'b0;
      end
    endcase
  end

  // Compute the result of one counting step, including end-of-range handling.
  always_comb begin
    // One extra bit keeps the carry (up) or the borrow (down).
    sum_s  = {1'b0, dataout_q} + {1'b0, step};
    diff_s = {1'b0, dataout_q} - {1'b0, step};
    if (up) begin
      next_s      = sum_s;
      dir_bound_s = hi;
    end else begin
      next_s      = diff_s;
      dir_bound_s = lo;
    end
    // A borrow sets the top bit, so it lands on the "> hi" side and still
    // counts as out of range. Checking both bounds also catches a count that
    // was left outside freshly changed bounds.
    oor_s = (next_s > {1'b0, hi}) || (next_s < {1'b0, lo});

    cnt_step_d = next_s[DATA_WIDTH-1:0];
    tc_step_d  = 1'b0;
    if (sat_mode_s) begin
      if (oor_s) begin
        cnt_step_d = dir_bound_s;
      end else begin
        cnt_step_d = next_s[DATA_WIDTH-1:0];
      end
      // Pulse only on the transition onto the bound, not while parked there.
      tc_step_d = (cnt_step_d == dir_bound_s) && (dataout_q != dir_bound_s);
    end else begin
      if (oor_s) begin
        cnt_step_d = up ? lo : hi;
      end else begin
        cnt_step_d = next_s[DATA_WIDTH-1:0];
      end
      tc_step_d = oor_s;
    end
  end

  // Counter state, one-shot FSM and registered flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataout_q <= RST_VAL;
      tc_q      <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= ST_RUN;
    end else if (ld) begin
      dataout_q <= load_val_s;
      tc_q      <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (count_en_s) begin
            dataout_q <= cnt_step_d;
            tc_q      <= tc_step_d;
            ovf_q     <= ovf_q | oor_s;
            if (oneshot_s && tc_step_d) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              done_q  <= done_q;
              state_q <= ST_RUN;
            end
          end else begin
            tc_q <= 1'b0;
          end
        end
        ST_DONE: begin
          // Parked until a load or reset; en has no effect here.
          tc_q <= 1'b0;
        end
        default: begin
          tc_q    <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign dataout = dataout_q;
  assign tc      = tc_q;
  assign done    = done_q;
  assign ovf     = ovf_q;
  assign cfg_err = cfg_err_s;

endmodule

// File: tb/tb_param_updown_counter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for param_updown_counter (DATA_WIDTH = 8, RST_VAL = 0).
// Directed scenarios check hand-derived values; a randomized phase checks
// against an integer-arithmetic reference model of the counting rules.
// -----------------------------------------------------------------------------
module tb_param_updown_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         ld;
  logic         up;
  logic [1:0]   mode;
  logic [W-1:0] step;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic [W-1:0] datain;
  logic [W-1:0] dataout;
  logic         tc;
  logic         done;
  logic         ovf;
  logic         cfg_err;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model state
  int m_cnt  = 0;
  bit m_tc   = 1'b0;
  bit m_done = 1'b0;
  bit m_ovf  = 1'b0;

  always #5 clk = ~clk;

  param_updown_counter #(
    .DATA_WIDTH (W),
    .RST_VAL    (8'h00)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .ld      (ld),
    .up      (up),
    .mode    (mode),
    .step    (step),
    .lo      (lo),
    .hi      (hi),
    .datain  (datain),
    .dataout (dataout),
    .tc      (tc),
    .done    (done),
    .ovf     (ovf),
    .cfg_err (cfg_err)
  );

  task automatic model_reset();
    m_cnt  = 0;
    m_tc   = 1'b0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // Apply the behavioural rules for one clock edge using the current inputs.
  task automatic model_edge();
    int nxt;
    int bnd;
    int nv;
    bit oor;
    bit cerr;
    cerr = (lo > hi);
    if (!rst) begin
      model_reset();
    end else if (ld) begin
      if (cerr)             m_cnt = int'(datain);
      else if (datain < lo) m_cnt = int'(lo);
      else if (datain > hi) m_cnt = int'(hi);
      else                  m_cnt = int'(datain);
      m_tc   = 1'b0;
      m_done = 1'b0;
      m_ovf  = 1'b0;
    end else if (en && !cerr && !m_done && step != 8'd0) begin
      nxt = up ? m_cnt + int'(step) : m_cnt - int'(step);
      oor = (nxt > int'(hi)) || (nxt < int'(lo));
      bnd = up ? int'(hi) : int'(lo);
      if (mode == 2'b01 || mode == 2'b10) begin
        nv   = oor ? bnd : nxt;
        m_tc = (nv == bnd) && (m_cnt != bnd);
        if (mode == 2'b10 && m_tc) m_done = 1'b1;
        m_cnt = nv;
      end else begin
        m_cnt = oor ? (up ? int'(lo) : int'(hi)) : nxt;
        m_tc  = oor;
      end
      if (oor) m_ovf = 1'b1;
    end else begin
      m_tc = 1'b0;
    end
  endtask

  // Advance one clock; outputs are stable when this returns.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; ld = 1'b0; up = 1'b1; mode = 2'b00;
    step = 8'd1; lo = 8'd0; hi = 8'd9; datain = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_run++;
    if ({dataout, tc, done, ovf, cfg_err} !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset: got cnt=%0d tc=%b done=%b ovf=%b cfg_err=%b, exp cnt=0 tc=0 done=0 ovf=0 cfg_err=0",
               dataout, tc, done, ovf, cfg_err);
      n_fail++;
    end
    rst = 1'b1;
  endtask

  task automatic test_basic_wrap();
    int ec[6] = '{6, 7, 8, 9, 0, 1};
    int et[6] = '{0, 0, 0, 0, 1, 0};
    int eo[6] = '{0, 0, 0, 0, 1, 1};
    mode = 2'b00; up = 1'b1; step = 8'd1; lo = 8'd0; hi = 8'd9;
    en = 1'b0; ld = 1'b1; datain = 8'd5;
    tick();
    ld = 1'b0;
    n_run++;
    if (dataout !== 8'd5 || tc !== 1'b0 || ovf !== 1'b0) begin
      $display("FAIL basic_load: got cnt=%0d tc=%b ovf=%b, exp cnt=5 tc=0 ovf=0", dataout, tc, ovf);
      n_fail++;
    end
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_run++;
      if (dataout !== 8'(ec[i]) || tc !== 1'(et[i]) || ovf !== 1'(eo[i]) || done !== 1'b0) begin
        $display("FAIL basic_wrap[%0d]: got cnt=%0d tc=%b ovf=%b done=%b, exp cnt=%0d tc=%0d ovf=%0d done=0",
                 i, dataout, tc, ovf, done, ec[i], et[i], eo[i]);
        n_fail++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_step_overshoot();
    int ec[3] = '{8, 0, 9};
    int et[3] = '{0, 1, 1};
    int eo[3] = '{0, 1, 1};
    mode = 2'b00; up = 1'b1; step = 8'd3; lo = 8'd0; hi = 8'd9;
    en = 1'b0; ld = 1'b1; datain = 8'd5;
    tick();
    ld = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) up = 1'b0;
      tick();
      n_run++;
      if (dataout !== 8'(ec[i]) || tc !== 1'(et[i]) || ovf !== 1'(eo[i])) begin
        $display("FAIL overshoot[%0d]: got cnt=%0d tc=%b ovf=%b, exp cnt=%0d tc=%0d ovf=%0d",
                 i, dataout, tc, ovf, ec[i], et[i], eo[i]);
        n_fail++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    int ec[4] = '{194, 198, 200, 200};
    int et[4] = '{0, 0, 1, 0};
    int eo[4] = '{0, 0, 1, 1};
    mode = 2'b01; up = 1'b1; step = 8'd4; lo = 8'd0; hi = 8'd200;
    en = 1'b0; ld = 1'b1; datain = 8'd190;
    tick();
    ld = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_run++;
      if (dataout !== 8'(ec[i]) || tc !== 1'(et[i]) || ovf !== 1'(eo[i]) || done !== 1'b0) begin
        $display("FAIL saturate[%0d]: got cnt=%0d tc=%b ovf=%b done=%b, exp cnt=%0d tc=%0d ovf=%0d done=0",
                 i, dataout, tc, ovf, done, ec[i], et[i], eo[i]);
        n_fail++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_oneshot();
    int ec[5] = '{4, 3, 3, 3, 3};
    int et[5] = '{0, 1, 0, 0, 0};
    int ed[5] = '{0, 1, 1, 1, 1};
    mode = 2'b10; up = 1'b0; step = 8'd1; lo = 8'd3; hi = 8'd255;
    en = 1'b0; ld = 1'b1; datain = 8'd5;
    tick();
    ld = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_run++;
      if (dataout !== 8'(ec[i]) || tc !== 1'(et[i]) || done !== 1'(ed[i]) || ovf !== 1'b0) begin
        $display("FAIL oneshot[%0d]: got cnt=%0d tc=%b done=%b ovf=%b, exp cnt=%0d tc=%0d done=%0d ovf=0",
                 i, dataout, tc, done, ovf, ec[i], et[i], ed[i]);
        n_fail++;
      end
    end
    ld = 1'b1; datain = 8'd7;
    tick();
    n_run++;
    if (dataout !== 8'd7 || done !== 1'b0 || tc !== 1'b0) begin
      $display("FAIL oneshot_reload: got cnt=%0d done=%b tc=%b, exp cnt=7 done=0 tc=0", dataout, done, tc);
      n_fail++;
    end
    ld = 1'b0;
    tick();
    n_run++;
    if (dataout !== 8'd6 || done !== 1'b0) begin
      $display("FAIL oneshot_resume: got cnt=%0d done=%b, exp cnt=6 done=0", dataout, done);
      n_fail++;
    end
    en = 1'b0;
  endtask

  task automatic test_load_priority();
    mode = 2'b00; up = 1'b1; step = 8'd1; lo = 8'd0; hi = 8'd100;
    en = 1'b1; ld = 1'b1; datain = 8'd250;
    tick();
    ld = 1'b0; en = 1'b0;
    n_run++;
    if (dataout !== 8'd100 || tc !== 1'b0 || ovf !== 1'b0 || done !== 1'b0) begin
      $display("FAIL load_clamp: got cnt=%0d tc=%b ovf=%b done=%b, exp cnt=100 tc=0 ovf=0 done=0",
               dataout, tc, ovf, done);
      n_fail++;
    end
  endtask

  task automatic test_cfg_err();
    mode = 2'b00; up = 1'b1; step = 8'd1; lo = 8'd10; hi = 8'd5; en = 1'b1;
    #1;
    n_run++;
    if (cfg_err !== 1'b1) begin
      $display("FAIL cfg_err_set: got %b, exp 1", cfg_err);
      n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_run++;
      if (dataout !== 8'd100 || tc !== 1'b0) begin
        $display("FAIL cfg_err_frozen[%0d]: got cnt=%0d tc=%b, exp cnt=100 tc=0", i, dataout, tc);
        n_fail++;
      end
    end
    ld = 1'b1; datain = 8'd200;
    tick();
    ld = 1'b0;
    tick();
    n_run++;
    if (dataout !== 8'd200 || tc !== 1'b0) begin
      $display("FAIL cfg_err_load: got cnt=%0d tc=%b, exp cnt=200 tc=0", dataout, tc);
      n_fail++;
    end
    en = 1'b0; lo = 8'd0; hi = 8'd255;
    #1;
    n_run++;
    if (cfg_err !== 1'b0) begin
      $display("FAIL cfg_err_clear: got %b, exp 0", cfg_err);
      n_fail++;
    end
  endtask

  task automatic test_step_zero();
    mode = 2'b00; up = 1'b1; lo = 8'd0; hi = 8'd255; step = 8'd1;
    ld = 1'b1; datain = 8'd50; en = 1'b0;
    tick();
    ld = 1'b0; step = 8'd0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_run++;
      if (dataout !== 8'd50 || tc !== 1'b0 || ovf !== 1'b0) begin
        $display("FAIL step_zero[%0d]: got cnt=%0d tc=%b ovf=%b, exp cnt=50 tc=0 ovf=0", i, dataout, tc, ovf);
        n_fail++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    mode = 2'b01; up = 1'b1; step = 8'd4; lo = 8'd0; hi = 8'h7F;
    en = 1'b0; ld = 1'b1; datain = 8'h7C;
    tick();
    ld = 1'b0; en = 1'b1;
    tick();
    n_run++;
    if (dataout !== 8'h7F || tc !== 1'b1 || ovf !== 1'b1) begin
      $display("FAIL pre_reset: got cnt=%0h tc=%b ovf=%b, exp cnt=7f tc=1 ovf=1", dataout, tc, ovf);
      n_fail++;
    end
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    n_run++;
    if ({dataout, tc, done, ovf} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL async_reset: got cnt=%0h tc=%b done=%b ovf=%b, exp cnt=00 tc=0 done=0 ovf=0",
               dataout, tc, done, ovf);
      n_fail++;
    end
    @(posedge clk);
    #1;
    n_run++;
    if (dataout !== 8'h00) begin
      $display("FAIL reset_hold: got cnt=%0h, exp 00", dataout);
      n_fail++;
    end
    rst = 1'b1; en = 1'b0; step = 8'd1;
    tick();
    n_run++;
    if (dataout !== 8'h00 || tc !== 1'b0) begin
      $display("FAIL post_reset_idle: got cnt=%0h tc=%b, exp cnt=00 tc=0", dataout, tc);
      n_fail++;
    end
    en = 1'b1;
    tick();
    n_run++;
    if (dataout !== 8'h01) begin
      $display("FAIL post_reset_count: got cnt=%0h, exp 01", dataout);
      n_fail++;
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      ld     = ($urandom_range(0, 9) == 0);
      en     = ($urandom_range(0, 3) != 0);
      up     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      step   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) begin
        lo = 8'($urandom_range(0, 60));
        hi = 8'($urandom_range(40, 255));
      end
      datain = 8'($urandom_range(0, 255));
      tick();
      n_run++;
      if ({dataout, tc, done, ovf, cfg_err} !== {8'(m_cnt), m_tc, m_done, m_ovf, (lo > hi)}) begin
        $display("FAIL random[%0d]: got cnt=%0d tc=%b done=%b ovf=%b cfg_err=%b, exp cnt=%0d tc=%b done=%b ovf=%b cfg_err=%b",
                 i, dataout, tc, done, ovf, cfg_err, m_cnt, m_tc, m_done, m_ovf, (lo > hi));
        n_fail++;
      end
    end
    en = 1'b0; ld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_wrap();
    test_step_overshoot();
    test_saturate();
    test_oneshot();
    test_load_priority();
    test_cfg_err();
    test_step_zero();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor to the team's basic load/enable counter.
- Adds up/down direction, programmable step, runtime bounds [lo,hi], and three end-of-range modes: wrap, saturate and one-shot.
- Adds terminal-count pulse, done flag, sticky overflow and config-error flag.
- Used as a general timer/index generator inside datapath and test infrastructure blocks.

Parameters:
- DATA_WIDTH, 8, width of count, load, step and bound values.
- RST_VAL, 0, dataout value on reset; must fit DATA_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately; release is synchronised by the caller).
- en  input  1  count enable; one step per clock while high.
- ld  input  1  synchronous load of datain.
- up  input  1  direction: 1 = increment, 0 = decrement.
- mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as 00).
- step  input  DATA_WIDTH  unsigned increment/decrement magnitude.
- lo  input  DATA_WIDTH  lower bound, inclusive.
- hi  input  DATA_WIDTH  upper bound, inclusive.
- datain  input  DATA_WIDTH  load value.
- dataout  output  DATA_WIDTH  current count (registered).
- tc  output  1  one-cycle terminal-count pulse.
- done  output  1  one-shot finished; level signal.
- ovf  output  1  sticky: any wrap or clamp since last load or reset.
- cfg_err  output  1  combinational: lo > hi.

Behaviour:
- Reset (rst=0, async): dataout=RST_VAL, tc=0, done=0, ovf=0, FSM=RUN.
- Priority per clock edge: reset > ld > en. With en=0 and ld=0, all state holds and tc=0.
- Load:
  - dataout <= datain clamped to [lo,hi].
  - done<=0, ovf<=0, tc<=0, FSM<=RUN.
  - Load has 1-cycle latency; dataout shows the value on the next cycle.
- cfg_err=1: counting is frozen (en ignored); ld still accepted, stored unclamped.
- Arithmetic:
  - Compute next = dataout ± step in DATA_WIDTH+1 bits so carry/borrow is never lost.
  - Out of range means next > hi (up) or next < lo (down, including borrow).
- step=0: dataout holds, tc=0, no state change.
- Mode wrap: if next is out of range, dataout <= lo (up) or hi (down), remainder discarded; tc=1 for that cycle; ovf<=1. Otherwise dataout<=next.
- Mode saturate:
  - If next is out of range, dataout <= bound (hi up, lo down) and ovf<=1.
  - tc=1 only on the update where dataout changes from non-bound to bound (exact hit or clamp).
  - While parked at the bound, no further tc.
- Mode one-shot, FSM states RUN and DONE:
  - RUN: behaves as saturate. On the update that reaches the bound, tc=1, done<=1, FSM<=DONE.
  - DONE: en ignored; dataout, done held. Exit only via ld or reset.
- Changing mode, up, lo or hi mid-count takes effect on the next enabled edge.
  - If dataout is then outside the new bounds, the next enabled step treats it as out of range and applies the mode rule.
- Simultaneous ld and en: load wins; no count that cycle.
- tc is registered; it is high in the same cycle dataout first shows the terminal value.
- Reset asserted mid-count or in DONE: immediate return to reset values, no tc glitch.

Test Plan:
- Basic count, mode=00, up=1, step=1, lo=0, hi=9: rst release, ld datain=5, then en for 6 cycles -> dataout 6,7,8,9,0,1; tc=1 only in the cycle dataout=0; ovf=1.
- Step overshoot with wrap, step=3, lo=0, hi=9, ld 5, en -> dataout 8 then 0 with tc=1. Then up=0, step=3 from 0 -> dataout 9 (wrap to hi), tc=1.
- Saturate, mode=01, up=1, step=4, hi=200, ld 190, en 4 cycles -> dataout 194, 198, 200 (tc=1, ovf=1), 200 (tc=0).
- One-shot, mode=10, up=0, step=1, lo=3, ld 5, en 5 cycles -> dataout 4, 3 (tc=1, done=1), then holds at 3 with en=1. Then ld 7 -> done=0, counting resumes.
- Corner cases:
  - ld=1 with en=1, datain=250, hi=100 -> dataout=100 (clamped), no tc.
  - lo=10, hi=5 -> cfg_err=1, en has no effect.
  - step=0 -> dataout holds.
- Async reset: assert rst=0 mid-cycle while counting at 0x7F -> dataout=0x00, tc/done/ovf=0 before the next clk edge. Release -> counting resumes only after en.
